load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage of the RV32I core. Consumes the decoder's mem_read, mem_write, mem_size
//  and mem_unsigned controls with the ALU address and rs2 data, and runs a req/gnt/rvalid
//  transaction on the data-memory bus. Returns a sign- or zero-extended load result, or a
//  store acknowledgement, tagged with rd for writeback. Only one transaction is in flight.
// PARAMETERS
//  TIMEOUT  256  max cycles in REQ+WAIT before bus-fault response; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk           in   1   core clock
//  rst_n         in   1   async active-low reset
//  req_valid     in   1   execute presents a memory op
//  req_ready     out  1   high in IDLE only; accept = req_valid & req_ready
//  mem_read      in   1   load (from decoder)
//  mem_write     in   1   store (from decoder); wins if both set
//  mem_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  mem_unsigned  in   1   zero-extend load (LBU/LHU)
//  addr          in   32  effective byte address
//  store_data    in   32  rs2 value
//  rd_addr       in   5   load destination
//  dmem_req      out  1   bus request, held until dmem_gnt
//  dmem_we       out  1   1 = write
//  dmem_addr     out  32  {addr[31:2],2'b00}
//  dmem_be       out  4   byte enables
//  dmem_wdata    out  32  lane-replicated store data
//  dmem_gnt      in   1   request accepted this cycle
//  dmem_rvalid   in   1   response/ack; earliest cycle after gnt
//  dmem_rdata    in   32  read word
//  resp_valid    out  1   one-cycle completion pulse
//  resp_err      out  2   00 ok, 01 misaligned/illegal size, 10 bus timeout
//  resp_rd       out  5   captured rd_addr; 0 for stores
//  resp_rdata    out  32  formatted load data; 0 for stores and errors
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0 except req_ready=1; timeout counter 0.
//    Reset mid-transaction drops dmem_req at once. Any pending response is discarded.
//  - FSM: IDLE -accept, aligned, load/store-> REQ; IDLE -accept, misaligned-> ERR;
//    IDLE -accept, neither read nor write-> RESP (err 00, no bus traffic);
//    REQ -dmem_gnt-> WAIT; WAIT -dmem_rvalid-> RESP; ERR -> RESP; RESP -> IDLE.
//  - All request fields are registered on accept. dmem_addr/we/be/wdata stay stable from
//    REQ until leaving WAIT. dmem_req=1 only in REQ.
//  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11 always. No bus request.
//  - Store lanes: byte be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}; half be=4'b0011<<addr[1:0],
//    wdata={2{sd[15:0]}}; word be=4'hF, wdata=sd. Loads drive the same be, with wdata=0.
//  - Load format: w = dmem_rdata >> (8*addr[1:0]). Byte is {24{~uns & w[7]}},w[7:0].
//    Half is {16{~uns & w[15]}},w[15:0]. Word is w. Result is captured on rvalid in WAIT.
//  - Timeout: counter clears on accept and increments each cycle in REQ/WAIT. When it reaches
//    TIMEOUT, go to RESP with err 10 and drop dmem_req. A later stray rvalid is ignored.
//  - dmem_gnt outside REQ and dmem_rvalid outside WAIT are ignored.
//  - resp_valid=1 only in RESP, for exactly one cycle. req_ready returns the cycle after RESP.
//  - Min latency: accept T, gnt T+1, rvalid T+2, resp_valid T+3, next accept T+4.
// TESTING
//  - SB addr=0x103, sd=0x12345678, gnt T+1, rvalid T+2 -> be=4'b1000, wdata=0x78787878,
//    dmem_addr=0x100, resp_valid T+3, err 00.
//  - LB addr=0x202, rdata=0x00800000 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; rd echoed.
//  - LHU addr=0x1001 -> dmem_req never asserted, resp_valid at T+2, err 01, rdata 0.
//  - LW with gnt low 3 cycles -> dmem_req/addr/be held stable; response 1 cycle after rvalid.
//  - TIMEOUT=8, gnt never -> resp err 10 exactly 8 cycles after REQ entry; later rvalid ignored.
//  - rst_n low during WAIT -> dmem_req/resp_valid 0 at once, req_ready=1; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundle for the load/store unit: the request/response channel from the execute stage
// and the req/gnt/rvalid data-memory bus. The LSU uses the slave view; the environment uses master.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd_addr;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        resp_valid;
   logic [1:0]  resp_err;
   logic [4:0]  resp_rd;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, store_data, rd_addr,
      output dmem_gnt, dmem_rvalid, dmem_rdata,
      input  req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  resp_valid, resp_err, resp_rd, resp_rdata
   );

   modport slave (
      input  req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, store_data, rd_addr,
      input  dmem_gnt, dmem_rvalid, dmem_rdata,
      output req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output resp_valid, resp_err, resp_rd, resp_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage: one in-flight load/store on a req/gnt/rvalid bus, with lane steering,
// load sign/zero extension, alignment checking and a bus timeout. All outputs are flops.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave bus
);

   localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_ERR  = 3'd3;
   localparam logic [2:0] ST_RESP = 3'd4;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         2'b00:   mis = 1'b0;
         2'b01:   mis = lo[0];
         2'b10:   mis = (lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << lo;
         2'b01:   be = 4'b0011 << lo;
         default: be = 4'hF;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sd);
      logic [31:0] wd;
      case (size)
         2'b00:   wd = {4{sd[7:0]}};
         2'b01:   wd = {2{sd[15:0]}};
         default: wd = sd;
      endcase
      return wd;
   endfunction

   function automatic logic [31:0] load_format(input logic [1:0] size, input logic uns,
                                               input logic [1:0] lo, input logic [31:0] rdata);
      logic [31:0] w;
      logic [31:0] res;
      w = rdata >> {lo, 3'b000};
      case (size)
         2'b00:   res = {{24{~uns & w[7]}}, w[7:0]};
         2'b01:   res = {{16{~uns & w[15]}}, w[15:0]};
         default: res = w;
      endcase
      return res;
   endfunction

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [1:0]    lo_q, lo_d;
   logic          store_q, store_d;
   logic [4:0]    rd_q, rd_d;
   logic [1:0]    err_q, err_d;

   logic          req_ready_q, req_ready_d;
   logic          dmem_req_q, dmem_req_d;
   logic          dmem_we_q, dmem_we_d;
   logic [31:0]   dmem_addr_q, dmem_addr_d;
   logic [3:0]    dmem_be_q, dmem_be_d;
   logic [31:0]   dmem_wdata_q, dmem_wdata_d;
   logic          resp_valid_q, resp_valid_d;
   logic [1:0]    resp_err_q, resp_err_d;
   logic [4:0]    resp_rd_q, resp_rd_d;
   logic [31:0]   resp_rdata_q, resp_rdata_d;

   logic          accept_s;
   logic          bus_op_s;
   logic [31:0]   rdata_s;

   // Next-state, request capture and registered-output computation.
   always_comb begin
      accept_s     = bus.req_valid & req_ready_q;
      bus_op_s     = bus.mem_read | bus.mem_write;
      state_d      = state_q;
      cnt_d        = cnt_q;
      size_d       = size_q;
      uns_d        = uns_q;
      lo_d         = lo_q;
      store_d      = store_q;
      rd_d         = rd_q;
      err_d        = err_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_be_d    = dmem_be_q;
      dmem_wdata_d = dmem_wdata_q;
      rdata_s      = 32'h0000_0000;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               size_d  = bus.mem_size;
               uns_d   = bus.mem_unsigned;
               lo_d    = bus.addr[1:0];
               store_d = bus.mem_write;
               rd_d    = bus.rd_addr;
               cnt_d   = {CW{1'b0}};
               // An op with neither read nor write touches no memory, so alignment is moot.
               if (!bus_op_s) begin
                  state_d = ST_RESP;
                  err_d   = ERR_NONE;
               end else if (is_misaligned(bus.mem_size, bus.addr[1:0])) begin
                  state_d = ST_ERR;
                  err_d   = ERR_ALIGN;
               end else begin
                  state_d      = ST_REQ;
                  err_d        = ERR_NONE;
                  dmem_we_d    = bus.mem_write;
                  dmem_addr_d  = {bus.addr[31:2], 2'b00};
                  dmem_be_d    = lane_be(bus.mem_size, bus.addr[1:0]);
                  dmem_wdata_d = bus.mem_write ? lane_wdata(bus.mem_size, bus.store_data)
                                               : 32'h0000_0000;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + CW'(1);
            // Timeout beats a grant in the last allowed cycle so REQ+WAIT never exceeds TIMEOUT.
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               err_d   = ERR_TIMEOUT;
            end else if (bus.dmem_gnt) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.dmem_rvalid) begin
               state_d = ST_RESP;
               if (!store_q) begin
                  rdata_s = load_format(size_q, uns_q, lo_q, bus.dmem_rdata);
               end else begin
                  rdata_s = 32'h0000_0000;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               err_d   = ERR_TIMEOUT;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_ERR:  state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      req_ready_d  = (state_d == ST_IDLE);
      dmem_req_d   = (state_d == ST_REQ);
      resp_valid_d = (state_d == ST_RESP);
      resp_err_d   = resp_valid_d ? err_d : ERR_NONE;
      resp_rd_d    = (resp_valid_d && !store_d) ? rd_d : 5'd0;
      resp_rdata_d = resp_valid_d ? rdata_s : 32'h0000_0000;
   end

   // State, captured request fields and output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= {CW{1'b0}};
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         lo_q         <= 2'b00;
         store_q      <= 1'b0;
         rd_q         <= 5'd0;
         err_q        <= ERR_NONE;
         req_ready_q  <= 1'b1;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 32'h0000_0000;
         dmem_be_q    <= 4'h0;
         dmem_wdata_q <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_err_q   <= ERR_NONE;
         resp_rd_q    <= 5'd0;
         resp_rdata_q <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         lo_q         <= lo_d;
         store_q      <= store_d;
         rd_q         <= rd_d;
         err_q        <= err_d;
         req_ready_q  <= req_ready_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_be_q    <= dmem_be_d;
         dmem_wdata_q <= dmem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rd_q    <= resp_rd_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.dmem_req   = dmem_req_q;
   assign bus.dmem_we    = dmem_we_q;
   assign bus.dmem_addr  = dmem_addr_q;
   assign bus.dmem_be    = dmem_be_q;
   assign bus.dmem_wdata = dmem_wdata_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rd    = resp_rd_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against an arithmetic reference model of lane
// steering, load extension, alignment and timeout rules.
module tb_load_store_unit;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   load_store_unit_if lsu_if ();

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (lsu_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] m_be(input int size, input int lo);
      int nbytes;
      nbytes = 1 << size;
      return 4'(((1 << nbytes) - 1) << lo);
   endfunction

   function automatic logic [31:0] m_wdata(input int size, input logic [31:0] sd);
      if (size == 0) return {24'h0, sd[7:0]} * 32'h0101_0101;
      if (size == 1) return {16'h0, sd[15:0]} * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] m_load(input int size, input bit uns, input int lo,
                                          input logic [31:0] word);
      logic [31:0] w;
      logic [31:0] mask;
      int nbits;
      nbits = 8 << size;
      w     = word >> (8 * lo);
      mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
      w     = w & mask;
      if (!uns && nbits < 32 && w[nbits-1]) w = w | ~mask;
      return w;
   endfunction

   task automatic clear_inputs();
      lsu_if.req_valid    = 1'b0;
      lsu_if.mem_read     = 1'b0;
      lsu_if.mem_write    = 1'b0;
      lsu_if.mem_size     = 2'b00;
      lsu_if.mem_unsigned = 1'b0;
      lsu_if.addr         = 32'h0;
      lsu_if.store_data   = 32'h0;
      lsu_if.rd_addr      = 5'd0;
      lsu_if.dmem_gnt     = 1'b0;
      lsu_if.dmem_rvalid  = 1'b0;
      lsu_if.dmem_rdata   = 32'h0;
   endtask

   // Presents one request at a negedge in IDLE; the accept edge is the following posedge.
   task automatic present(input bit rd, input bit wr, input int size, input bit uns,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rda);
      check("ready_idle", {31'h0, lsu_if.req_ready}, 32'h1);
      lsu_if.req_valid    = 1'b1;
      lsu_if.mem_read     = rd;
      lsu_if.mem_write    = wr;
      lsu_if.mem_size     = 2'(size);
      lsu_if.mem_unsigned = uns;
      lsu_if.addr         = a;
      lsu_if.store_data   = sd;
      lsu_if.rd_addr      = rda;
      @(negedge clk);
      lsu_if.req_valid    = 1'b0;
      lsu_if.addr         = $urandom();
      lsu_if.store_data   = $urandom();
      lsu_if.mem_size     = 2'($urandom_range(0, 3));
      lsu_if.mem_unsigned = 1'($urandom_range(0, 1));
      lsu_if.rd_addr      = 5'($urandom_range(0, 31));
   endtask

   task automatic do_op(input bit rd, input bit wr, input int size, input bit uns,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rda,
                        input int gdly, input int rdly, input logic [31:0] word);
      bit          noop;
      bit          mis;
      logic [4:0]  exp_rd;
      logic [31:0] exp_wd;
      noop   = !rd && !wr;
      mis    = (size == 3) || (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00);
      exp_rd = wr ? 5'd0 : rda;
      exp_wd = wr ? m_wdata(size, sd) : 32'h0;
      present(rd, wr, size, uns, a, sd, rda);
      if (noop) begin
         check("noop_dmem_req", {31'h0, lsu_if.dmem_req}, 32'h0);
      end else if (mis) begin
         check("mis_dmem_req", {31'h0, lsu_if.dmem_req}, 32'h0);
         check("mis_early_resp", {31'h0, lsu_if.resp_valid}, 32'h0);
         @(negedge clk);
         check("mis_dmem_req2", {31'h0, lsu_if.dmem_req}, 32'h0);
      end else begin
         for (int i = 0; i <= gdly; i++) begin
            check("req_dmem_req", {31'h0, lsu_if.dmem_req}, 32'h1);
            check("req_resp_valid", {31'h0, lsu_if.resp_valid}, 32'h0);
            check("req_addr", lsu_if.dmem_addr, {a[31:2], 2'b00});
            check("req_be", {28'h0, lsu_if.dmem_be}, {28'h0, m_be(size, int'(a[1:0]))});
            check("req_we", {31'h0, lsu_if.dmem_we}, {31'h0, wr});
            check("req_wdata", lsu_if.dmem_wdata, exp_wd);
            lsu_if.dmem_gnt    = (i == gdly);
            lsu_if.dmem_rvalid = 1'($urandom_range(0, 1));
            lsu_if.dmem_rdata  = $urandom();
            @(negedge clk);
         end
         lsu_if.dmem_gnt    = 1'b0;
         lsu_if.dmem_rvalid = 1'b0;
         for (int i = 0; i <= rdly; i++) begin
            check("wait_dmem_req", {31'h0, lsu_if.dmem_req}, 32'h0);
            check("wait_resp_valid", {31'h0, lsu_if.resp_valid}, 32'h0);
            check("wait_addr", lsu_if.dmem_addr, {a[31:2], 2'b00});
            check("wait_be", {28'h0, lsu_if.dmem_be}, {28'h0, m_be(size, int'(a[1:0]))});
            check("wait_wdata", lsu_if.dmem_wdata, exp_wd);
            lsu_if.dmem_gnt    = 1'($urandom_range(0, 1));
            lsu_if.dmem_rvalid = (i == rdly);
            lsu_if.dmem_rdata  = (i == rdly) ? word : $urandom();
            @(negedge clk);
         end
         lsu_if.dmem_gnt    = 1'b0;
         lsu_if.dmem_rvalid = 1'b0;
      end
      check("resp_valid", {31'h0, lsu_if.resp_valid}, 32'h1);
      check("resp_err", {30'h0, lsu_if.resp_err}, (mis && !noop) ? 32'h1 : 32'h0);
      check("resp_rd", {27'h0, lsu_if.resp_rd}, {27'h0, exp_rd});
      check("resp_rdata", lsu_if.resp_rdata,
            (noop || mis || wr) ? 32'h0 : m_load(size, uns, int'(a[1:0]), word));
      @(negedge clk);
      check("resp_pulse_end", {31'h0, lsu_if.resp_valid}, 32'h0);
      check("ready_after", {31'h0, lsu_if.req_ready}, 32'h1);
   endtask

   task automatic do_timeout(input bit gnt_first);
      present(1'b1, 1'b0, 2, 1'b0, 32'h0000_0440, 32'h0, 5'd7);
      for (int i = 0; i < int'(TO); i++) begin
         check("to_dmem_req", {31'h0, lsu_if.dmem_req}, (gnt_first && i != 0) ? 32'h0 : 32'h1);
         check("to_no_resp", {31'h0, lsu_if.resp_valid}, 32'h0);
         lsu_if.dmem_gnt = gnt_first && (i == 0);
         @(negedge clk);
      end
      lsu_if.dmem_gnt = 1'b0;
      check("to_resp_valid", {31'h0, lsu_if.resp_valid}, 32'h1);
      check("to_resp_err", {30'h0, lsu_if.resp_err}, 32'h2);
      check("to_resp_rdata", lsu_if.resp_rdata, 32'h0);
      check("to_resp_rd", {27'h0, lsu_if.resp_rd}, 32'h7);
      check("to_dmem_req_off", {31'h0, lsu_if.dmem_req}, 32'h0);
      lsu_if.dmem_rvalid = 1'b1;
      lsu_if.dmem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      lsu_if.dmem_rvalid = 1'b0;
      check("to_stray_rvalid", {31'h0, lsu_if.resp_valid}, 32'h0);
      check("to_ready", {31'h0, lsu_if.req_ready}, 32'h1);
      @(negedge clk);
      check("to_stray_rvalid2", {31'h0, lsu_if.resp_valid}, 32'h0);
   endtask

   task automatic do_reset_mid(input bit in_wait);
      present(1'b1, 1'b0, 2, 1'b0, 32'h0000_0040, 32'h0, 5'd9);
      if (in_wait) begin
         lsu_if.dmem_gnt = 1'b1;
         @(negedge clk);
         lsu_if.dmem_gnt = 1'b0;
         check("rst_in_wait", {31'h0, lsu_if.dmem_req}, 32'h0);
      end else begin
         check("rst_in_req", {31'h0, lsu_if.dmem_req}, 32'h1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("rst_dmem_req", {31'h0, lsu_if.dmem_req}, 32'h0);
      check("rst_resp_valid", {31'h0, lsu_if.resp_valid}, 32'h0);
      check("rst_ready", {31'h0, lsu_if.req_ready}, 32'h1);
      lsu_if.dmem_rvalid = 1'b1;
      lsu_if.dmem_rdata  = 32'h1234_5678;
      @(negedge clk);
      lsu_if.dmem_rvalid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_no_resp", {31'h0, lsu_if.resp_valid}, 32'h0);
      do_op(1'b1, 1'b0, 2, 1'b0, 32'h0000_0080, 32'h0, 5'd11, 0, 0, 32'hCAFE_F00D);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          rd;
      bit          wr;
      int          r;
      logic [31:0] a;
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      check("rst_state_ready", {31'h0, lsu_if.req_ready}, 32'h1);
      check("rst_state_req", {31'h0, lsu_if.dmem_req}, 32'h0);
      check("rst_state_resp", {31'h0, lsu_if.resp_valid}, 32'h0);
      check("rst_state_err", {30'h0, lsu_if.resp_err}, 32'h0);
      check("rst_state_be", {28'h0, lsu_if.dmem_be}, 32'h0);
      check("rst_state_addr", lsu_if.dmem_addr, 32'h0);
      check("rst_state_rdata", lsu_if.resp_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(1'b0, 1'b1, 0, 1'b0, 32'h0000_0103, 32'h1234_5678, 5'd3, 0, 0, 32'h0);
      do_op(1'b1, 1'b0, 0, 1'b0, 32'h0000_0202, 32'h0, 5'd5, 0, 0, 32'h0080_0000);
      do_op(1'b1, 1'b0, 0, 1'b1, 32'h0000_0202, 32'h0, 5'd6, 0, 0, 32'h0080_0000);
      do_op(1'b1, 1'b0, 1, 1'b1, 32'h0000_1001, 32'h0, 5'd8, 0, 0, 32'h0);
      do_op(1'b1, 1'b0, 2, 1'b0, 32'h0000_2004, 32'h0, 5'd10, 3, 0, 32'h8765_4321);
      do_op(1'b0, 1'b0, 2, 1'b0, 32'h0000_3000, 32'h0, 5'd12, 0, 0, 32'h0);
      do_timeout(1'b0);
      do_timeout(1'b1);
      do_reset_mid(1'b1);
      do_reset_mid(1'b0);

      for (int n = 0; n < 200; n++) begin
         r  = $urandom_range(0, 7);
         rd = (r >= 1 && r <= 4);
         wr = (r == 1) || (r >= 5);
         a  = $urandom();
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         do_op(rd, wr, $urandom_range(0, 3), 1'($urandom_range(0, 1)), a, $urandom(),
               5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 2), $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
